// File: rtl/data_mem_system.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : data_mem_system                                              |
// | Purpose : Data-side memory: byte-strobed word RAM plus MMIO block      |
// |           (tohost, 64-bit mtime, UART TX FIFO). Optional mtimecmp      |
// |           compare interrupt when DMEM_MTIMECMP_EN is defined.          |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module data_mem_system #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 1024,
    parameter int              TXDEPTH   = 4,
    parameter logic [XLEN-1:0] MMIO_BASE = XLEN'(32'h1000_0000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   IEUAdr,
    input  logic [XLEN-1:0]   WriteData,
    input  logic              MemEn,
    input  logic              WriteEn,
    input  logic [XLEN/8-1:0] WriteByteEn,
    output logic [XLEN-1:0]   ReadData,
    output logic [7:0]        TxData,
    output logic              TxValid,
    input  logic              TxReady,
    output logic              Done,
    output logic              Pass,
    output logic              TimerIrq
);

    localparam int              c_NB        = XLEN / 8;
    localparam int              c_OFF       = $clog2(c_NB);
    localparam int              c_AW        = $clog2(DEPTH);
    localparam int              c_PW        = $clog2(TXDEPTH);
    localparam logic [XLEN-1:0] c_RAM_BYTES = XLEN'(DEPTH * c_NB);
    localparam logic [XLEN-1:0] c_XONE      = XLEN'(1);
    localparam logic [63:0]     c_TONE      = 64'd1;
    localparam logic [c_PW:0]   c_PONE      = (c_PW + 1)'(1);

    localparam logic [7:0] c_OFF_TOHOST = 8'h00;
    localparam logic [7:0] c_OFF_MTLO   = 8'h08;
    localparam logic [7:0] c_OFF_MTHI   = 8'h0C;
    localparam logic [7:0] c_OFF_UART   = 8'h10;
    localparam logic [7:0] c_OFF_CMPLO  = 8'h18;
    localparam logic [7:0] c_OFF_CMPHI  = 8'h1C;

    logic            w_load;
    logic            w_store;
    logic            w_ram_sel;
    logic            w_mmio_sel;
    logic [7:0]      w_off;
    logic [c_AW-1:0] w_word;

    assign w_load     = MemEn & ~WriteEn;
    assign w_store    = MemEn & WriteEn;
    assign w_ram_sel  = (IEUAdr < c_RAM_BYTES);
    assign w_mmio_sel = (IEUAdr[XLEN-1:8] == MMIO_BASE[XLEN-1:8]);
    assign w_off      = IEUAdr[7:0];
    assign w_word     = IEUAdr[c_AW+c_OFF-1:c_OFF];

    // ---------------- word RAM (contents survive reset) ----------------
    logic [XLEN-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (w_store && w_ram_sel) begin
            for (int b = 0; b < c_NB; b++) begin
                if (WriteByteEn[b]) begin
                    r_mem[w_word][8*b +: 8] <= WriteData[8*b +: 8];
                end
            end
        end
    end

    // ---------------- tohost / Done / Pass ----------------
    logic [XLEN-1:0] r_tohost;
    logic            r_done;
    logic            r_pass;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tohost <= '0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else if (w_store && w_mmio_sel && (w_off == c_OFF_TOHOST) &&
                     !r_done && (WriteData != '0)) begin
            r_tohost <= WriteData;
            r_done   <= 1'b1;
            r_pass   <= (WriteData == c_XONE);
        end
    end

    assign Done = r_done;
    assign Pass = r_pass;

    // ---------------- free-running 64-bit timer ----------------
    logic [63:0]     r_mtime;
    logic [XLEN-1:0] w_mtime_lo_rd;
    logic [XLEN-1:0] w_mtime_hi_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mtime <= '0;
        end else begin
            r_mtime <= r_mtime + c_TONE;
        end
    end

    generate
        if (XLEN == 32) begin : g_x32
            // A LO read snapshots the upper half so a following HI read is coherent.
            logic [31:0] r_shadow;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_shadow <= '0;
                end else if (w_load && w_mmio_sel && (w_off == c_OFF_MTLO)) begin
                    r_shadow <= r_mtime[63:32];
                end
            end

            assign w_mtime_lo_rd = r_mtime[31:0];
            assign w_mtime_hi_rd = r_shadow;
        end else begin : g_x64
            assign w_mtime_lo_rd = r_mtime[XLEN-1:0];
            assign w_mtime_hi_rd = '0;
        end
    endgenerate

    // ---------------- UART TX FIFO ----------------
    logic [7:0]  r_fifo [TXDEPTH];
    logic [c_PW:0] r_wptr;
    logic [c_PW:0] r_rptr;
    logic        r_ovf;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push_req;
    logic        w_push;

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[c_PW] != r_rptr[c_PW]) &&
                        (r_wptr[c_PW-1:0] == r_rptr[c_PW-1:0]);
    assign w_pop      = !w_empty && TxReady;
    assign w_push_req = w_store && w_mmio_sel && (w_off == c_OFF_UART) && WriteByteEn[0];
    // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
    assign w_push     = w_push_req && (!w_full || w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
            for (int i = 0; i < TXDEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo[r_wptr[c_PW-1:0]] <= WriteData[7:0];
                r_wptr                   <= r_wptr + c_PONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PONE;
            end
            if (w_push_req && !w_push) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign TxData  = r_fifo[r_rptr[c_PW-1:0]];
    assign TxValid = !w_empty;

    // ---------------- optional timer compare ----------------
    logic [XLEN-1:0] w_cmp_lo_rd;
    logic [XLEN-1:0] w_cmp_hi_rd;

`ifdef DMEM_MTIMECMP_EN
    logic [63:0] r_mtimecmp;
    logic        r_irq;
    logic        w_cmp_wr_lo;
    logic        w_cmp_wr_hi;

    assign w_cmp_wr_lo = w_store && w_mmio_sel && (w_off == c_OFF_CMPLO);
    assign w_cmp_wr_hi = w_store && w_mmio_sel && (w_off == c_OFF_CMPHI);

    generate
        if (XLEN == 32) begin : g_cmp32
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_mtimecmp <= '1;
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_cmp_wr_lo && WriteByteEn[b]) begin
                            r_mtimecmp[8*b +: 8] <= WriteData[8*b +: 8];
                        end
                        if (w_cmp_wr_hi && WriteByteEn[b]) begin
                            r_mtimecmp[32+8*b +: 8] <= WriteData[8*b +: 8];
                        end
                    end
                end
            end

            assign w_cmp_lo_rd = r_mtimecmp[31:0];
            assign w_cmp_hi_rd = r_mtimecmp[63:32];
        end else begin : g_cmp64
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_mtimecmp <= '1;
                end else begin
                    for (int b = 0; b < c_NB; b++) begin
                        if (w_cmp_wr_lo && WriteByteEn[b]) begin
                            r_mtimecmp[8*b +: 8] <= WriteData[8*b +: 8];
                        end
                    end
                end
            end

            assign w_cmp_lo_rd = r_mtimecmp[XLEN-1:0];
            assign w_cmp_hi_rd = '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_mtime >= r_mtimecmp);
        end
    end

    assign TimerIrq = r_irq;
`else
    assign w_cmp_lo_rd = '0;
    assign w_cmp_hi_rd = '0;
    assign TimerIrq    = 1'b0;
`endif

    // ---------------- load path ----------------
    logic [XLEN-1:0] w_rdata;
    logic [XLEN-1:0] r_rdata;

    always_comb begin
        w_rdata = '0;
        if (w_ram_sel) begin
            w_rdata = r_mem[w_word];
        end else if (w_mmio_sel) begin
            case (w_off)
                c_OFF_TOHOST: w_rdata = r_tohost;
                c_OFF_MTLO:   w_rdata = w_mtime_lo_rd;
                c_OFF_MTHI:   w_rdata = w_mtime_hi_rd;
                c_OFF_UART:   w_rdata = {{(XLEN-3){1'b0}}, r_ovf, w_empty, w_full};
                c_OFF_CMPLO:  w_rdata = w_cmp_lo_rd;
                c_OFF_CMPHI:  w_rdata = w_cmp_hi_rd;
                default:      w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_load) begin
            r_rdata <= w_rdata;
        end
    end

    assign ReadData = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_system.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_data_mem_system                                           |
// | Purpose : Directed, table-driven self-checking bench for               |
// |           data_mem_system (XLEN=32 build).                             |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_data_mem_system;

    localparam logic [31:0] MB = 32'h1000_0000;
    localparam int          NV = 23;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IEUAdr;
    logic [31:0] WriteData;
    logic        MemEn;
    logic        WriteEn;
    logic [3:0]  WriteByteEn;
    logic [31:0] ReadData;
    logic [7:0]  TxData;
    logic        TxValid;
    logic        TxReady;
    logic        Done;
    logic        Pass;
    logic        TimerIrq;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] tb_mtime;
    vec_t        tbl [NV];

    data_mem_system #(
        .XLEN      (32),
        .DEPTH     (1024),
        .TXDEPTH   (4),
        .MMIO_BASE (32'h1000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .IEUAdr      (IEUAdr),
        .WriteData   (WriteData),
        .MemEn       (MemEn),
        .WriteEn     (WriteEn),
        .WriteByteEn (WriteByteEn),
        .ReadData    (ReadData),
        .TxData      (TxData),
        .TxValid     (TxValid),
        .TxReady     (TxReady),
        .Done        (Done),
        .Pass        (Pass),
        .TimerIrq    (TimerIrq)
    );

    always #5 clk = ~clk;

    // Reference cycle counter for the timer
    always @(posedge clk or posedge reset) begin
        if (reset) tb_mtime <= 64'd0;
        else       tb_mtime <= tb_mtime + 64'd1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic access(input logic we, input logic [31:0] adr,
                          input logic [31:0] wd, input logic [3:0] be);
        @(negedge clk);
        MemEn = 1'b1; WriteEn = we; IEUAdr = adr; WriteData = wd; WriteByteEn = be;
        @(posedge clk);
        #1;
        MemEn = 1'b0; WriteEn = 1'b0;
    endtask

    task automatic load_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
        access(1'b0, adr, 32'h0, 4'h0);
        chk(name, ReadData, exp);
    endtask

    task automatic rd_mtime_lo(input string name);
        logic [31:0] exp;
        @(negedge clk);
        MemEn = 1'b1; WriteEn = 1'b0; IEUAdr = MB + 32'h8; WriteByteEn = 4'h0;
        exp = tb_mtime[31:0];
        @(posedge clk);
        #1;
        MemEn = 1'b0;
        chk(name, ReadData, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Push while the sink pops in the same cycle
    task automatic push_pop(input logic [7:0] b);
        @(negedge clk);
        TxReady = 1'b1;
        MemEn = 1'b1; WriteEn = 1'b1; IEUAdr = MB + 32'h10; WriteData = {24'h0, b}; WriteByteEn = 4'h1;
        @(posedge clk);
        #1;
        MemEn = 1'b0; WriteEn = 1'b0;
    endtask

    task automatic drain(input string name, input logic [7:0] first, input int n);
        @(negedge clk);
        TxReady = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s%0d", name, i), {55'h0, TxValid, TxData}, {55'h0, 1'b1, first + 8'(i)});
            @(negedge clk);
        end
        chk({name, "_empty"}, {63'h0, TxValid}, 64'h0);
        TxReady = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 32'h0000_0040, 32'hAABB_CCDD, 4'hF, 32'h0};
        tbl[1]  = '{1'b1, 32'h0000_0040, 32'h1122_3344, 4'h5, 32'h0};
        tbl[2]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'hAA22_CC44};
        tbl[3]  = '{1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 4'hF, 32'h0};
        tbl[4]  = '{1'b1, 32'h0000_0044, 32'h0000_0099, 4'h1, 32'h0};
        tbl[5]  = '{1'b1, 32'h0000_0047, 32'h1234_5678, 4'h8, 32'h0};
        tbl[6]  = '{1'b0, 32'h0000_0045, 32'h0,         4'h0, 32'h12AD_BE99};
        tbl[7]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'hAA22_CC44};
        tbl[8]  = '{1'b1, 32'h0000_0FFC, 32'h0102_0304, 4'hF, 32'h0};
        tbl[9]  = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h0102_0304};
        tbl[10] = '{1'b1, 32'h0000_0000, 32'h5555_5555, 4'hF, 32'h0};
        tbl[11] = '{1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 32'h0};
        tbl[12] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h5555_5555};
        tbl[13] = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0};
        tbl[14] = '{1'b0, 32'h2000_0000, 32'h0,         4'h0, 32'h0};
        tbl[15] = '{1'b0, MB,            32'h0,         4'h0, 32'h0};
        tbl[16] = '{1'b0, MB + 32'h04,   32'h0,         4'h0, 32'h0};
        tbl[17] = '{1'b1, MB + 32'h10,   32'h0000_00AB, 4'hE, 32'h0};
        tbl[18] = '{1'b0, MB + 32'h10,   32'h0,         4'h0, 32'h2};
        tbl[19] = '{1'b1, MB + 32'h14,   32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[20] = '{1'b0, MB + 32'h14,   32'h0,         4'h0, 32'h0};
        tbl[21] = '{1'b1, MB + 32'h18,   32'h0000_000A, 4'hF, 32'h0};
`ifdef DMEM_MTIMECMP_EN
        tbl[22] = '{1'b0, MB + 32'h18,   32'h0,         4'h0, 32'h0000_000A};
`else
        tbl[22] = '{1'b0, MB + 32'h18,   32'h0,         4'h0, 32'h0};
`endif

        reset = 1'b0; MemEn = 1'b0; WriteEn = 1'b0; IEUAdr = '0;
        WriteData = '0; WriteByteEn = '0; TxReady = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("rst_rdata",  {32'h0, ReadData}, 64'h0);
        chk("rst_done",   {63'h0, Done},     64'h0);
        chk("rst_pass",   {63'h0, Pass},     64'h0);
        chk("rst_irq",    {63'h0, TimerIrq}, 64'h0);
        chk("rst_txv",    {63'h0, TxValid},  64'h0);
        chk("rst_txdata", {56'h0, TxData},   64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Table of loads/stores: RAM strobes, decode boundaries, MMIO reads
        for (int i = 0; i < NV; i++) begin
            access(tbl[i].we, tbl[i].adr, tbl[i].wd, tbl[i].be);
            if (!tbl[i].we) chk($sformatf("vec%0d", i), {32'h0, ReadData}, {32'h0, tbl[i].exp});
        end

        // Exactly one cycle of load latency, and hold while idle
        load_chk("lat_prev", 32'h40, 32'hAA22_CC44);
        @(negedge clk);
        MemEn = 1'b1; WriteEn = 1'b0; IEUAdr = 32'h44;
        #1 chk("lat_before_edge", {32'h0, ReadData}, {32'h0, 32'hAA22_CC44});
        @(posedge clk);
        #1 chk("lat_after_edge", {32'h0, ReadData}, {32'h0, 32'h12AD_BE99});
        MemEn = 1'b0; WriteEn = 1'b1; IEUAdr = 32'h40; WriteData = 32'h0; WriteByteEn = 4'hF;
        repeat (3) @(posedge clk);
        #1 chk("hold_idle", {32'h0, ReadData}, {32'h0, 32'h12AD_BE99});
        WriteEn = 1'b0;
        load_chk("memen0_nowrite", 32'h40, 32'hAA22_CC44);

        // Timer: LO read, HI read two cycles later from the shadow
        do_reset();
        repeat (2) @(negedge clk);
        rd_mtime_lo("mtime_lo_a");
        @(posedge clk);
        load_chk("mtime_hi", MB + 32'h0C, 32'h0);
        access(1'b1, MB + 32'h08, 32'hFFFF_FFFF, 4'hF);
        rd_mtime_lo("mtime_lo_after_wr");
        rd_mtime_lo("mtime_lo_b");

        // UART overflow and in-order drain
        for (int i = 0; i < 5; i++) access(1'b1, MB + 32'h10, 32'h41 + i, 4'h1);
        chk("tx_head", {55'h0, TxValid, TxData}, {55'h0, 1'b1, 8'h41});
        load_chk("uart_full_ovf", MB + 32'h10, 32'h5);
        drain("drain", 8'h41, 4);
        load_chk("uart_ovf_empty", MB + 32'h10, 32'h6);

        // Push and pop together with two entries queued
        access(1'b1, MB + 32'h10, 32'h50, 4'h1);
        access(1'b1, MB + 32'h10, 32'h51, 4'h1);
        push_pop(8'h52);
        TxReady = 1'b0;
        chk("pp_head", {56'h0, TxData}, 64'h51);
        load_chk("pp_status", MB + 32'h10, 32'h4);
        drain("pp", 8'h51, 2);

        // Push into a full FIFO while popping
        for (int i = 0; i < 4; i++) access(1'b1, MB + 32'h10, 32'h60 + i, 4'h1);
        load_chk("full_status", MB + 32'h10, 32'h5);
        push_pop(8'h64);
        TxReady = 1'b0;
        drain("fpp", 8'h61, 4);

        // Push into an empty FIFO with the sink ready: no pop that cycle
        push_pop(8'h70);
        chk("epp_valid", {55'h0, TxValid, TxData}, {55'h0, 1'b1, 8'h70});
        @(posedge clk);
        #1 chk("epp_popped", {63'h0, TxValid}, 64'h0);
        TxReady = 1'b0;

        // tohost pass, sticky, then fail after reset
        do_reset();
        @(negedge clk);
        MemEn = 1'b1; WriteEn = 1'b1; IEUAdr = MB; WriteData = 32'h1; WriteByteEn = 4'hF;
        #1 chk("done_pre", {63'h0, Done}, 64'h0);
        @(posedge clk);
        #1;
        MemEn = 1'b0; WriteEn = 1'b0;
        chk("pass_done", {62'h0, Done, Pass}, 64'h3);
        access(1'b1, MB, 32'h3, 4'hF);
        chk("sticky", {62'h0, Done, Pass}, 64'h3);
        load_chk("tohost_rd1", MB, 32'h1);
        do_reset();
        access(1'b1, MB, 32'h0, 4'hF);
        chk("zero_wr", {63'h0, Done}, 64'h0);
        access(1'b1, MB, 32'h3, 4'hF);
        chk("fail_done", {62'h0, Done, Pass}, 64'h2);
        load_chk("tohost_rd3", MB, 32'h3);

        // Asynchronous reset between edges with FIFO busy and Done set
        access(1'b1, MB + 32'h10, 32'h33, 4'h1);
        access(1'b1, MB + 32'h10, 32'h34, 4'h1);
        load_chk("pre_async_rd", 32'h40, 32'hAA22_CC44);
        chk("pre_async", {62'h0, TxValid, Done}, 64'h3);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_txv",   {63'h0, TxValid},  64'h0);
        chk("async_done",  {63'h0, Done},     64'h0);
        chk("async_rdata", {32'h0, ReadData}, 64'h0);
        chk("async_txd",   {56'h0, TxData},   64'h0);
        @(negedge clk);
        reset = 1'b0;

`ifdef DMEM_MTIMECMP_EN
        do_reset();
        access(1'b1, MB + 32'h18, 32'd10, 4'hF);
        access(1'b1, MB + 32'h1C, 32'd0, 4'hF);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            chk($sformatf("irq_at_%0d", tb_mtime), {63'h0, TimerIrq}, {63'h0, tb_mtime >= 64'd11});
        end
        load_chk("cmp_hi_rd", MB + 32'h1C, 32'h0);
`else
        access(1'b1, MB + 32'h1C, 32'h0, 4'hF);
        load_chk("cmp_hi_absent", MB + 32'h1C, 32'h0);
        repeat (20) @(negedge clk);
        chk("irq_absent", {63'h0, TimerIrq}, 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
